// File: rtl/button_debouncer_pkg.sv
// Shared constants for the button debouncer.
//   - Default debounce / long-press durations for the 12 MHz board clock.
//   - Counter-width helpers so the top and the channel size their counters
//     the same way.
package button_debouncer_pkg;

    localparam int BOARD_CLK_HZ        = 12_000_000;
    // 65536 cycles at 12 MHz is roughly 5.5 ms of stable contact.
    localparam int DEF_DEBOUNCE_CYCLES = 65536;
    // 8388608 cycles at 12 MHz is roughly 0.7 s of hold time.
    localparam int DEF_LONG_CYCLES     = 8388608;

    // The debounce counter only ever has to reach cycles-1.
    function automatic int dcnt_width(input int cycles);
        return $clog2(cycles);
    endfunction

    // The hold counter has to represent the saturated value itself.
    function automatic int hcnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

    localparam int DEF_DCNT_W = dcnt_width(DEF_DEBOUNCE_CYCLES);
    localparam int DEF_HCNT_W = hcnt_width(DEF_LONG_CYCLES);

endpackage

// File: rtl/button_debouncer_channel.sv
// One debounce channel: two-flop synchroniser, stability counter, accepted
// level, press/release pulses and a saturating hold counter for long press.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   p              polarity-corrected raw pin (asynchronous)
//   level          debounced level, 1 = pressed
//   press_pulse    one cycle on an accepted 0->1 change
//   release_pulse  one cycle on an accepted 1->0 change
//   long_pulse     one cycle once per press after LONG_CYCLES held
module debounce_channel
    import button_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic p,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int DW = dcnt_width(DEBOUNCE_CYCLES);
    localparam int HW = hcnt_width(LONG_CYCLES);
    localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HCNT_SAT  = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] HCNT_FIRE = HW'(LONG_CYCLES - 1);

    logic          s0_reg, s1_reg;
    logic [DW-1:0] dcnt_reg, dcnt_next;
    logic          state_reg, state_next;
    logic          press_reg, press_next;
    logic          release_reg, release_next;
    logic [HW-1:0] hcnt_reg, hcnt_next;
    logic          long_reg, long_next;

    always_comb begin
        dcnt_next    = dcnt_reg;
        state_next   = state_reg;
        press_next   = 1'b0;
        release_next = 1'b0;
        hcnt_next    = hcnt_reg;
        long_next    = 1'b0;

        // Any sample that agrees with the accepted level discards all
        // progress toward a change.
        if (s1_reg == state_reg) begin
            dcnt_next = '0;
        end else if (dcnt_reg == DCNT_LAST) begin
            state_next   = s1_reg;
            dcnt_next    = '0;
            press_next   = s1_reg;
            release_next = ~s1_reg;
        end else begin
            dcnt_next = dcnt_reg + DW'(1);
        end

        // Hold counter runs off the accepted level and sticks at the
        // saturation value, so the long pulse fires only once per press.
        if (!state_reg) begin
            hcnt_next = '0;
        end else if (hcnt_reg < HCNT_SAT) begin
            hcnt_next = hcnt_reg + HW'(1);
            long_next = (hcnt_reg == HCNT_FIRE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_reg      <= 1'b0;
            s1_reg      <= 1'b0;
            dcnt_reg    <= '0;
            state_reg   <= 1'b0;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
            hcnt_reg    <= '0;
            long_reg    <= 1'b0;
        end else begin
            s0_reg      <= p;
            s1_reg      <= s0_reg;
            dcnt_reg    <= dcnt_next;
            state_reg   <= state_next;
            press_reg   <= press_next;
            release_reg <= release_next;
            hcnt_reg    <= hcnt_next;
            long_reg    <= long_next;
        end
    end

    assign level         = state_reg;
    assign press_pulse   = press_reg;
    assign release_pulse = release_reg;
    assign long_pulse    = long_reg;

endmodule

// File: rtl/button_debouncer.sv
// N-channel pushbutton debouncer. Each raw pin is polarity-corrected and fed
// to an independent debounce channel; all outputs are registered.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   btn_raw      asynchronous raw button pins
//   btn_state    debounced level per channel, 1 = pressed
//   btn_press    one-cycle pulse on accepted press
//   btn_release  one-cycle pulse on accepted release
//   btn_long     one-cycle pulse once per press after the long-hold time
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_state,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long
);

    // Inversion happens before the synchroniser so every channel works in
    // "1 = pressed" terms and reset (all zero) means "released".
    logic [N_BTN-1:0] p;
    assign p = btn_raw ^ {N_BTN{ACTIVE_LOW}};

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .LONG_CYCLES    (LONG_CYCLES)
        ) u_chan (
            .clk          (clk),
            .rst          (rst),
            .p            (p[gi]),
            .level        (btn_state[gi]),
            .press_pulse  (btn_press[gi]),
            .release_pulse(btn_release[gi]),
            .long_pulse   (btn_long[gi])
        );
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: an active-high build (unit 0) and an
// active-low build (unit 1), both with 2 channels, debounce 4, long 10.
// A behavioural model tracks, per channel, how long the synchronised input
// has disagreed with the accepted level and how long the level has been held.
module tb_button_debouncer;

    localparam int DC = 4;
    localparam int LC = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] raw_a, raw_b;
    logic [1:0] state_a, press_a, rel_a, long_a;
    logic [1:0] state_b, press_b, rel_b, long_b;

    int n_vec = 0;
    int n_err = 0;

    button_debouncer #(.N_BTN(2), .DEBOUNCE_CYCLES(DC), .LONG_CYCLES(LC), .ACTIVE_LOW(1'b0)) dut_a (
        .clk(clk), .rst(rst), .btn_raw(raw_a),
        .btn_state(state_a), .btn_press(press_a), .btn_release(rel_a), .btn_long(long_a));

    button_debouncer #(.N_BTN(2), .DEBOUNCE_CYCLES(DC), .LONG_CYCLES(LC), .ACTIVE_LOW(1'b1)) dut_b (
        .clk(clk), .rst(rst), .btn_raw(raw_b),
        .btn_state(state_b), .btn_press(press_b), .btn_release(rel_b), .btn_long(long_b));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [1:0] got, input logic [1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Indexed [unit][channel]. pin_d1/pin_d2 are the pressed-sense pin as
    // seen one and two edges ago; disagree counts consecutive edges on
    // which the two-edges-old sample differed from the accepted level.
    int m_d1[2][2], m_d2[2][2], m_lvl[2][2], m_disagree[2][2], m_held[2][2];
    int m_press[2][2], m_rel[2][2], m_long[2][2];

    always @(posedge clk) begin
        logic [1:0] pin;
        logic [1:0] e_st, e_pr, e_rl, e_lg;
        int seen, lvl_before;
        for (int u = 0; u < 2; u++) begin
            pin = (u == 0) ? raw_a : ~raw_b;
            for (int c = 0; c < 2; c++) begin
                m_press[u][c] = 0;
                m_rel[u][c]   = 0;
                m_long[u][c]  = 0;
                if (rst) begin
                    m_d1[u][c] = 0; m_d2[u][c] = 0; m_lvl[u][c] = 0;
                    m_disagree[u][c] = 0; m_held[u][c] = 0;
                end else begin
                    seen       = m_d2[u][c];
                    lvl_before = m_lvl[u][c];
                    m_d2[u][c] = m_d1[u][c];
                    m_d1[u][c] = int'(pin[c]);
                    if (seen != m_lvl[u][c]) m_disagree[u][c]++;
                    else                     m_disagree[u][c] = 0;
                    if (m_disagree[u][c] == DC) begin
                        m_lvl[u][c] = seen;
                        m_disagree[u][c] = 0;
                        if (seen == 1) m_press[u][c] = 1;
                        else           m_rel[u][c]   = 1;
                    end
                    if (lvl_before == 1) begin
                        if (m_held[u][c] < LC) begin
                            m_held[u][c]++;
                            if (m_held[u][c] == LC) m_long[u][c] = 1;
                        end
                    end else begin
                        m_held[u][c] = 0;
                    end
                end
            end
        end
        #1;
        for (int u = 0; u < 2; u++) begin
            for (int c = 0; c < 2; c++) begin
                e_st[c] = (m_lvl[u][c] != 0);
                e_pr[c] = (m_press[u][c] != 0);
                e_rl[c] = (m_rel[u][c] != 0);
                e_lg[c] = (m_long[u][c] != 0);
            end
            if (u == 0) begin
                check("a.state", state_a, e_st); check("a.press", press_a, e_pr);
                check("a.release", rel_a, e_rl); check("a.long", long_a, e_lg);
            end else begin
                check("b.state", state_b, e_st); check("b.press", press_b, e_pr);
                check("b.release", rel_b, e_rl); check("b.long", long_b, e_lg);
            end
        end
    end

    // ---------------- stimulus with literal pins ----------------
    int hold[4];
    logic val[4];

    initial begin
        rst = 1'b1; raw_a = 2'b00; raw_b = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        check("lit.reset_state", state_a, 2'b00);
        check("lit.reset_press_b", press_b, 2'b00);
        @(negedge clk) rst = 1'b0;
        repeat (4) @(posedge clk);

        // Clean press, then long press timing.
        @(negedge clk) raw_a = 2'b01;
        repeat (6) @(posedge clk);
        #1;
        check("lit.press_state", state_a, 2'b01);
        check("lit.press_pulse", press_a, 2'b01);
        @(posedge clk); #1;
        check("lit.press_drop", press_a, 2'b00);
        repeat (9) @(posedge clk); #1;
        check("lit.long_fire", long_a, 2'b01);
        @(posedge clk); #1;
        check("lit.long_once", long_a, 2'b00);
        repeat (5) @(posedge clk);

        // Release.
        @(negedge clk) raw_a = 2'b00;
        repeat (6) @(posedge clk); #1;
        check("lit.release_pulse", rel_a, 2'b01);
        check("lit.release_state", state_a, 2'b00);
        repeat (3) @(posedge clk);

        // Bounce rejection.
        for (int i = 0; i < 8; i++) @(negedge clk) raw_a = (i % 2 == 0) ? 2'b01 : 2'b00;
        @(negedge clk) raw_a = 2'b00;
        repeat (8) @(posedge clk); #1;
        check("lit.bounce_state", state_a, 2'b00);
        for (int i = 0; i < 3; i++) @(negedge clk) raw_a = 2'b01;
        @(negedge clk) raw_a = 2'b00;
        @(negedge clk) raw_a = 2'b01;
        repeat (5) @(posedge clk); #1;
        check("lit.glitch_no_early", press_a, 2'b00);
        @(posedge clk); #1;
        check("lit.glitch_press", press_a, 2'b01);
        @(negedge clk) raw_a = 2'b00;
        repeat (10) @(posedge clk);

        // Reset mid-press.
        @(negedge clk) raw_a = 2'b01;
        repeat (12) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        check("lit.rst_state", state_a, 2'b00);
        @(posedge clk); #1;
        check("lit.rst_long", long_a, 2'b00);
        @(negedge clk) rst = 1'b0;
        repeat (6) @(posedge clk); #1;
        check("lit.rst_repress", press_a, 2'b01);
        repeat (10) @(posedge clk); #1;
        check("lit.rst_long_again", long_a, 2'b01);
        @(negedge clk) raw_a = 2'b00;
        repeat (8) @(posedge clk);

        // Active-low build: both pins pulled low together.
        #1;
        check("lit.idle_high_state", state_b, 2'b00);
        @(negedge clk) raw_b = 2'b00;
        repeat (6) @(posedge clk); #1;
        check("lit.simul_press", press_b, 2'b11);
        @(negedge clk) raw_b = 2'b11;
        repeat (8) @(posedge clk);

        // Randomised phase: per-channel held levels of varying length,
        // occasional single-cycle reset.
        for (int k = 0; k < 4; k++) begin hold[k] = 0; val[k] = 1'b0; end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 499) == 0);
            for (int k = 0; k < 4; k++) begin
                if (hold[k] == 0) begin
                    val[k]  = 1'($urandom_range(0, 1));
                    hold[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 25))
                                                          : int'($urandom_range(1, 6));
                end else begin
                    hold[k]--;
                end
            end
            raw_a = {val[1], val[0]};
            raw_b = {val[3], val[2]};
        end
        @(negedge clk) rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
